// File: rtl/param_piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with valid/ready on both sides.
// Optional even-parity trailer bit enabled by defining SERIALIZE_PARITY_EN.
module param_piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             input_clock1_clk_1,
    input  logic             input_push_button1_reset_1,
    input  logic [WIDTH-1:0] input_data,
    input  logic             input_valid,
    output logic             output_ready,
    output logic             output_ser,
    output logic             output_ser_valid,
    input  logic             input_ser_ready,
    output logic             output_ser_last,
    output logic             output_load_shift,
    output logic [CNT_W-1:0] output_bit_cnt
);

    // state | meaning
    // IDLE  | waiting for a word, output_ready high, serial side idle
    // SHIFT | presenting frame bits, advancing on each downstream beat

`ifdef SERIALIZE_PARITY_EN
    localparam int SR_W = WIDTH + 1;
`else
    localparam int SR_W = WIDTH;
`endif
    localparam int               OUT_IDX  = MSB_FIRST ? SR_W - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SR_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   load_word;
    logic [SR_W-1:0]   shifted;
    logic              is_last;
    logic              beat;

    // The parity bit sits at the far end of the register so it leaves last.
    always_comb begin
`ifdef SERIALIZE_PARITY_EN
        if (MSB_FIRST) begin
            load_word = {input_data, ^input_data};
        end else begin
            load_word = {^input_data, input_data};
        end
`else
        load_word = input_data;
`endif
    end

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[SR_W-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg_q[SR_W-1:1]};
        end
    end

    assign is_last      = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign beat         = (state_q == SHIFT) && input_ser_ready;
    assign output_ready = (state_q == IDLE) || (is_last && input_ser_ready);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (input_valid) begin
                    shreg_d = load_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (is_last) begin
                        // Reload in the same beat for gapless back-to-back frames.
                        if (input_valid) begin
                            shreg_d = load_word;
                            cnt_d   = '0;
                        end else begin
                            shreg_d = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge input_clock1_clk_1 or posedge input_push_button1_reset_1) begin
        if (input_push_button1_reset_1) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign output_ser        = shreg_q[OUT_IDX];
    assign output_ser_valid  = (state_q == SHIFT);
    assign output_load_shift = (state_q == IDLE);
    assign output_ser_last   = is_last;
    assign output_bit_cnt    = cnt_q;

endmodule

// File: tb/tb_param_piso_serializer.sv
// Bench for param_piso_serializer: MSB-first and LSB-first instances share stimulus
// and are checked each cycle against a frame-level model; honours SERIALIZE_PARITY_EN.
module tb_param_piso_serializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);
`ifdef SERIALIZE_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  data = '0;
    logic          valid = 1'b0;
    logic          sready = 1'b0;

    logic          ready_m, ser_m, sval_m, last_m, ls_m;
    logic [CW-1:0] cnt_m;
    logic          ready_l, ser_l, sval_l, last_l, ls_l;
    logic [CW-1:0] cnt_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    param_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .input_clock1_clk_1        (clk),
        .input_push_button1_reset_1(rst),
        .input_data                (data),
        .input_valid               (valid),
        .output_ready              (ready_m),
        .output_ser                (ser_m),
        .output_ser_valid          (sval_m),
        .input_ser_ready           (sready),
        .output_ser_last           (last_m),
        .output_load_shift         (ls_m),
        .output_bit_cnt            (cnt_m)
    );

    param_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .input_clock1_clk_1        (clk),
        .input_push_button1_reset_1(rst),
        .input_data                (data),
        .input_valid               (valid),
        .output_ready              (ready_l),
        .output_ser                (ser_l),
        .output_ser_valid          (sval_l),
        .input_ser_ready           (sready),
        .output_ser_last           (last_l),
        .output_load_shift         (ls_l),
        .output_bit_cnt            (cnt_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: the word in flight and which frame bit is presented.
    logic          m_busy = 1'b0;
    int            m_idx  = 0;
    logic [W-1:0]  m_word = '0;
    logic          m_last;
    logic          m_rdy;

    assign m_last = m_busy && (m_idx == FLEN - 1);
    assign m_rdy  = !m_busy || (m_last && sready);

    function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
        if (idx >= W) return ^w;
        return msb ? w[W-1-idx] : w[idx];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
        end else begin
            if (m_busy && sready) begin
                if (m_last) m_busy <= 1'b0;
                else        m_idx  <= m_idx + 1;
            end
            if (m_rdy && valid) begin
                m_word <= data;
                m_idx  <= 0;
                m_busy <= 1'b1;
            end
        end
    end

    bq_t cap_m, cap_l, cap_last, cap_cnt;
    int  cyc_valid = 0;

    always @(negedge clk) begin
        chk("ready_m", ready_m, m_rdy);
        chk("ready_l", ready_l, m_rdy);
        chk("ser_valid_m", sval_m, m_busy);
        chk("ser_valid_l", sval_l, m_busy);
        chk("load_shift_m", ls_m, !m_busy);
        chk("load_shift_l", ls_l, !m_busy);
        chk("ser_last_m", last_m, m_last);
        chk("ser_last_l", last_l, m_last);
        if (m_busy) begin
            chk("ser_m", ser_m, exp_bit(m_word, m_idx, 1'b1));
            chk("ser_l", ser_l, exp_bit(m_word, m_idx, 1'b0));
            chk("bit_cnt_m", cnt_m, m_idx);
            chk("bit_cnt_l", cnt_l, m_idx);
        end
        if (sval_m) cyc_valid++;
        if (sval_m && sready) begin
            cap_m.push_back({7'd0, ser_m});
            cap_l.push_back({7'd0, ser_l});
            cap_last.push_back({7'd0, last_m});
            cap_cnt.push_back(8'(cnt_l));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        valid  = v;
        data   = d;
        sready = r;
    endtask

    task automatic clear_caps();
        cap_m.delete();
        cap_l.delete();
        cap_last.delete();
        cap_cnt.delete();
        cyc_valid = 0;
    endtask

    // e lists the expected sequence first-element-first from bit n-1 downward.
    task automatic chk_bits(input string nm, input bq_t q, input int n, input logic [15:0] e);
        chk({nm, "_len"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) chk(nm, q[i], {31'd0, e[n-1-i]});
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready_m"}, ready_m, 1'b1);
        chk({nm, "_ls_m"}, ls_m, 1'b1);
        chk({nm, "_ser_m"}, ser_m, 1'b0);
        chk({nm, "_sval_m"}, sval_m, 1'b0);
        chk({nm, "_last_m"}, last_m, 1'b0);
        chk({nm, "_cnt_m"}, cnt_m, 0);
        chk({nm, "_ready_l"}, ready_l, 1'b1);
        chk({nm, "_ser_l"}, ser_l, 1'b0);
        chk({nm, "_sval_l"}, sval_l, 1'b0);
        chk({nm, "_cnt_l"}, cnt_l, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        bit   found;

        #1 rst = 1'b1;
        #2 chk_reset_vals("reset");
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        tick();

        // 1011 MSB first / LSB first, free-running downstream
        clear_caps();
        drive(1'b1, 4'b1011, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        repeat (FLEN + 1) tick();
        chk_bits("t1_ser_msb", cap_m, FLEN, (FLEN == 5) ? 16'b10111 : 16'b1011);
        chk_bits("t1_last", cap_last, FLEN, (FLEN == 5) ? 16'b00001 : 16'b0001);
        chk("t1_ready_after", ready_m, 1'b1);
        chk("t1_ls_after", ls_m, 1'b1);
        chk_bits("t2_ser_lsb", cap_l, FLEN, (FLEN == 5) ? 16'b11011 : 16'b1101);
        for (int i = 0; i < cap_cnt.size(); i++) chk("t2_bit_cnt", cap_cnt[i], i);

        // back-to-back A then 5
        clear_caps();
        drive(1'b1, 4'hA, 1'b1);
        tick();
        drive(1'b1, 4'h5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ready_m) found = 1'b1;
            else tick();
        end
        chk("t3_ready_seen", found, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b1);
        repeat (FLEN + 1) tick();
        chk_bits("t3_ser", cap_m, 2 * FLEN, (FLEN == 5) ? 16'b1010001010 : 16'b10100101);
        chk("t3_valid_cycles", cyc_valid, 2 * FLEN);

        // stall for 3 cycles at bit 1
        clear_caps();
        drive(1'b1, 4'b1011, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_ser", ser_m, 1'b0);
            chk("t4_hold_cnt", cnt_m, 1);
            tick();
        end
        drive(1'b0, 4'b0000, 1'b1);
        repeat (FLEN + 1) tick();
        chk("t4_frame_cycles", cyc_valid, FLEN + 3);
        chk_bits("t4_ser", cap_m, FLEN, (FLEN == 5) ? 16'b10111 : 16'b1011);

        // reset mid-frame, then a clean frame
        drive(1'b1, 4'b1100, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1 chk_reset_vals("t5_reset");
        tick();
        rst = 1'b0;
        clear_caps();
        drive(1'b1, 4'b0110, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        repeat (FLEN + 1) tick();
        chk_bits("t5_ser", cap_m, FLEN, (FLEN == 5) ? 16'b01100 : 16'b0110);

`ifdef SERIALIZE_PARITY_EN
        clear_caps();
        drive(1'b1, 4'b1001, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        repeat (FLEN + 1) tick();
        chk_bits("t6_parity0", cap_m, FLEN, 16'b10010);
`endif

        // randomized traffic with back-pressure; source holds word until accepted
        acc = 1'b0;
        valid = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!valid || acc) begin
                valid = ($urandom_range(0, 2) != 0);
                data  = W'($urandom);
            end
            sready = ($urandom_range(0, 3) != 0);
            #1 acc = valid && ready_m;
            tick();
        end
        drive(1'b0, 4'b0000, 1'b1);
        repeat (FLEN + 2) tick();
        chk("end_idle", ls_m, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
